// File: rtl/shift_add_mult_if.sv
// Operand/result bundle between the ALU control and the shift-add multiplier.
interface shift_add_mult_if #(
    parameter int unsigned N = 4
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    // Requester side: issues operands, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, product
    );

    // Multiplier side.
    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/adder_cl.sv
// N-bit adder built from generate/propagate terms; used for the multiplier partial sums.
module adder_cl #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         ci_i,
    output logic [N-1:0] s_o,
    output logic         co_o
);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Carry chain from generate/propagate.
    always_comb begin
        c    = '0;
        c[0] = ci_i;
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s_o  = p ^ c[N-1:0];
    assign co_o = c[N];
endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned NxN shift-and-add multiplier; one partial-product add per clock.
module shift_add_mult #(
    parameter int unsigned N = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_add_mult_if.slave mul_io
);
    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   q_q, q_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;

    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic           co;
    logic [2*N-1:0] shifted;

    assign addend = q_q[0] ? m_q : '0;

    adder_cl #(
        .N (N)
    ) u_adder (
        .a_i  (acc_q),
        .b_i  (addend),
        .ci_i (1'b0),
        .s_o  (sum),
        .co_o (co)
    );

    // Right shift of {co,sum,Q}; the carry-out lands in the top bit of ACC.
    assign shifted = {co, sum, q_q[N-1:1]};

    // Next-state: operand capture in IDLE/DONE, one shift-add step per clock in RUN.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            StIdle, StDone: begin
                if (mul_io.start) begin
                    m_d     = mul_io.a;
                    q_d     = mul_io.b;
                    acc_d   = '0;
                    cnt_d   = CW'(N);
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                acc_d = shifted[2*N-1:N];
                q_d   = shifted[N-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d = shifted;
                    state_d   = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Status decoded straight from registered state.
    assign mul_io.busy    = (state_q == StRun);
    assign mul_io.done    = (state_q == StDone);
    assign mul_io.product = product_q;
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and sweep checks for shift_add_mult at N=4 and N=8.
module tb_shift_add_mult;
    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    shift_add_mult_if #(.N(4)) if4 ();
    shift_add_mult_if #(.N(8)) if8 ();

    shift_add_mult #(.N(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_io (if4)
    );

    shift_add_mult #(.N(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .mul_io (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one N=4 job from a negedge; returns at the negedge where done is seen.
    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        output int busy_cycles, output bit timed_out);
        busy_cycles = 0;
        timed_out   = 1'b0;
        if4.start = 1'b1;
        if4.a     = a;
        if4.b     = b;
        @(negedge clk);
        if4.start = 1'b0;
        if4.a     = 4'hx;
        if4.b     = 4'hx;
        for (int i = 0; i < 20; i++) begin
            if (if4.done) return;
            if (if4.busy) busy_cycles++;
            @(negedge clk);
        end
        timed_out = 1'b1;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, output bit timed_out);
        timed_out = 1'b0;
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        @(negedge clk);
        if8.start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (if8.done) return;
            @(negedge clk);
        end
        timed_out = 1'b1;
    endtask

    initial begin
        int  bc;
        bit  to;
        bit  saw_done;
        logic [7:0] ea;
        logic [7:0] eb;

        vecs[0] = '{a: 4'd0,  b: 4'd0,  exp: 8'h00};
        vecs[1] = '{a: 4'd15, b: 4'd15, exp: 8'hE1};
        vecs[2] = '{a: 4'd13, b: 4'd11, exp: 8'h8F};
        vecs[3] = '{a: 4'd7,  b: 4'd0,  exp: 8'h00};
        vecs[4] = '{a: 4'd2,  b: 4'd3,  exp: 8'h06};
        vecs[5] = '{a: 4'd4,  b: 4'd5,  exp: 8'h14};
        vecs[6] = '{a: 4'd9,  b: 4'd5,  exp: 8'h2D};

        if4.start = 1'b0; if4.a = '0; if4.b = '0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", 32'(if4.busy), 32'd0);
        check("reset_done", 32'(if4.done), 32'd0);
        check("reset_product", 32'(if4.product), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven jobs: product, busy length, single-cycle done.
        for (int i = 0; i < 7; i++) begin
            run4(vecs[i].a, vecs[i].b, bc, to);
            check($sformatf("vec%0d_timeout", i), 32'(to), 32'd0);
            check($sformatf("vec%0d_product", i), 32'(if4.product), 32'(vecs[i].exp));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd4);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(if4.done), 32'd0);
            check($sformatf("vec%0d_idle", i), 32'(if4.busy), 32'd0);
        end

        // Product holds across the next job until that job completes.
        run4(4'd13, 4'd11, bc, to);
        check("hold_first", 32'(if4.product), 32'h8F);
        @(negedge clk);
        if4.start = 1'b1; if4.a = 4'd7; if4.b = 4'd0;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        check("hold_mid_run", 32'(if4.product), 32'h8F);
        @(negedge clk);
        check("hold_mid_run2", 32'(if4.product), 32'h8F);
        @(negedge clk);
        @(negedge clk);
        check("hold_second_done", 32'(if4.done), 32'd1);
        check("hold_second_product", 32'(if4.product), 32'h00);
        @(negedge clk);

        // A start pulse during RUN is ignored.
        if4.start = 1'b1; if4.a = 4'd9; if4.b = 4'd5;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        if4.start = 1'b1; if4.a = 4'd3; if4.b = 4'd3;
        @(negedge clk);
        if4.start = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10 && !saw_done; i++) begin
            if (if4.done) saw_done = 1'b1;
            else @(negedge clk);
        end
        check("ignore_done_seen", 32'(saw_done), 32'd1);
        check("ignore_product", 32'(if4.product), 32'h2D);
        @(negedge clk);
        check("ignore_then_idle_busy", 32'(if4.busy), 32'd0);
        check("ignore_then_idle_done", 32'(if4.done), 32'd0);

        // Back-to-back: start held high through DONE.
        if4.start = 1'b1; if4.a = 4'd2; if4.b = 4'd3;
        @(negedge clk);
        saw_done = 1'b0;
        for (int i = 0; i < 10 && !saw_done; i++) begin
            if (if4.done) saw_done = 1'b1;
            else @(negedge clk);
        end
        check("b2b_first_seen", 32'(saw_done), 32'd1);
        check("b2b_first_product", 32'(if4.product), 32'h06);
        if4.a = 4'd6; if4.b = 4'd7;
        @(negedge clk);
        if4.start = 1'b0;
        check("b2b_no_bubble", 32'(if4.busy), 32'd1);
        bc = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 10 && !saw_done; i++) begin
            if (if4.done) saw_done = 1'b1;
            else begin
                if (if4.busy) bc++;
                @(negedge clk);
            end
        end
        check("b2b_second_seen", 32'(saw_done), 32'd1);
        check("b2b_second_busy", 32'(bc), 32'd4);
        check("b2b_second_product", 32'(if4.product), 32'h2A);
        @(negedge clk);

        // Asynchronous reset mid-operation.
        if4.start = 1'b1; if4.a = 4'd15; if4.b = 4'd15;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(if4.busy), 32'd0);
        check("async_done", 32'(if4.done), 32'd0);
        check("async_product", 32'(if4.product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if4.done || if4.busy) saw_done = 1'b1;
        end
        check("async_no_done_after", 32'(saw_done), 32'd0);
        run4(4'd4, 4'd5, bc, to);
        check("async_fresh_product", 32'(if4.product), 32'h14);
        @(negedge clk);

        // Exhaustive N=4 sweep.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run4(4'(x), 4'(y), bc, to);
                check($sformatf("sweep4_%0d_%0d", x, y), 32'(if4.product), 32'(x * y));
                @(negedge clk);
            end
        end

        // Random N=8 sweep plus extremes.
        for (int k = 0; k < 60; k++) begin
            ea = (k == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            eb = (k == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            run8(ea, eb, to);
            check($sformatf("sweep8_timeout_%0d", k), 32'(to), 32'd0);
            check($sformatf("sweep8_%0h_%0h", ea, eb), 32'(if8.product),
                  32'(int'(ea) * int'(eb)));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
